data_mem_store: RTL and testbench

- Backing store for the CPU data-memory port. It consumes the mem_addr / mem_read_en / mem_write_en / mem_write_val side of the data-memory interface and produces mem_read_val.
- Word-addressed synchronous RAM with 1-cycle registered read. A stall handshake makes the CPU wait one cycle on loads.
- After reset, a clear FSM zeroes every word before the store accepts any request.

---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_ram_array.sv | 35 +++
 rtl/data_mem_store.sv | 104 ++++++++++
 tb/tb_data_mem_store.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory backing store.
package data_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    localparam logic [DEF_DATA_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ_WAIT
    } mem_state_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous RAM: one write port plus a registered read that
// only updates when a read is launched, so the output holds between reads.
module data_ram_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array write; the storage itself carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data register: cleared on reset, loaded only when a read is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_store.sv
// Data-memory backing store: post-reset clear sequence, one-stall loads,
// zero-stall stores and a sticky error for simultaneous read+write requests.
module data_mem_store
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_write_val,
    output logic [DATA_WIDTH-1:0] mem_read_val,
    output logic                  mem_stall,
    output logic                  mem_ready,
    output logic                  mem_err
);

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  err_q;
    logic                  set_err;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    // State, clear counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state, RAM port muxing (clear counter vs CPU address), stall and error set.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = mem_addr;
        ram_wdata = mem_write_val;
        mem_stall = 1'b0;
        set_err   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = DATA_WIDTH'(ZERO_WORD);
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                mem_stall = mem_read_en | mem_write_en;
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (mem_write_en) begin
                    ram_we  = 1'b1;
                    set_err = mem_read_en;
                end else if (mem_read_en) begin
                    ram_re    = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // The still-held read enable belongs to the completing load.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_ready = (state_q != CLEAR);
    assign mem_err   = err_q;

    data_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we & ~reset),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re & ~reset),
        .raddr (mem_addr),
        .rdata (mem_read_val)
    );

endmodule

// File: tb/tb_data_mem_store.sv
// Directed self-checking bench for data_mem_store.
module tb_data_mem_store;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_val;
    logic [31:0] mem_read_val;
    logic        mem_stall;
    logic        mem_ready;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    data_mem_store #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val),
        .mem_stall     (mem_stall),
        .mem_ready     (mem_ready),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Counts not-ready cycles until mem_ready rises (bounded).
    task automatic count_clear(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_ready) break;
            n++;
        end
        tick();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input string name);
        mem_addr = a; mem_write_val = d; mem_write_en = 1'b1;
        @(negedge clk);
        chk({name, " wr stall"}, {31'd0, mem_stall}, 32'd0);
        tick();
        mem_write_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        mem_addr = a; mem_read_en = 1'b1;
        @(negedge clk);
        chk({name, " launch stall"}, {31'd0, mem_stall}, 32'd1);
        tick();
        @(negedge clk);
        chk({name, " wait stall"}, {31'd0, mem_stall}, 32'd0);
        chk({name, " data"}, mem_read_val, exp);
        tick();
        mem_read_en = 1'b0;
    endtask

    initial begin
        int n;
        int stall_bad;

        vecs[0]  = '{1'b1, 8'hA5, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'h10, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 8'h10, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 8'h01, 32'h1111_1111};
        vecs[4]  = '{1'b0, 8'h02, 32'h2222_2222};
        vecs[5]  = '{1'b1, 8'h01, 32'h1111_1111};
        vecs[6]  = '{1'b1, 8'h02, 32'h2222_2222};
        vecs[7]  = '{1'b0, 8'hFF, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 8'h00, 32'h0BAD_C0DE};
        vecs[9]  = '{1'b1, 8'hFF, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 8'h00, 32'h0BAD_C0DE};
        vecs[11] = '{1'b1, 8'h10, 32'hDEAD_BEEF};

        mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0; mem_write_val = '0;
        reset = 1'b1;
        tick();

        // Reset state and initial clear length.
        apply_reset(2);
        @(negedge clk);
        chk("rst read_val", mem_read_val, 32'd0);
        chk("rst ready", {31'd0, mem_ready}, 32'd0);
        chk("rst err", {31'd0, mem_err}, 32'd0);
        tick();
        count_clear(n);
        chk("clear len", n, 32'd255);

        // Table-driven stores and loads (back-to-back, RAW, address extremes).
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_read) do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            else                 do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
        end

        // Idle with junk on address/data: no writes, read value holds.
        mem_addr = 8'h10; mem_write_val = 32'h5555_AAAA;
        repeat (3) tick();
        @(negedge clk);
        chk("hold read_val", mem_read_val, 32'hDEAD_BEEF);
        chk("idle stall", {31'd0, mem_stall}, 32'd0);
        tick();
        do_read(8'h10, 32'hDEAD_BEEF, "x-safe");

        // Simultaneous read+write: write wins, sticky error.
        mem_addr = 8'h20; mem_write_val = 32'h1234_5678;
        mem_read_en = 1'b1; mem_write_en = 1'b1;
        @(negedge clk);
        chk("rw stall", {31'd0, mem_stall}, 32'd0);
        chk("rw err pre", {31'd0, mem_err}, 32'd0);
        tick();
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rw err sticky", {31'd0, mem_err}, 32'd1);
        tick();
        do_read(8'h20, 32'h1234_5678, "rw data");
        @(negedge clk);
        chk("rw err after read", {31'd0, mem_err}, 32'd1);
        tick();

        // Read request held during clear from cycle 100.
        apply_reset(1);
        stall_bad = 0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin
                mem_addr = 8'h10; mem_read_en = 1'b1;
            end
            @(negedge clk);
            if (mem_ready) break;
            if (i == 0 && mem_err !== 1'b0) stall_bad++;
            if (mem_stall !== (i >= 100)) stall_bad++;
            n++;
            tick();
        end
        chk("clr2 len", n, 32'd256);
        chk("clr2 stall pattern", stall_bad, 32'd0);
        chk("clr2 ready stall", {31'd0, mem_stall}, 32'd1);
        tick();
        @(negedge clk);
        chk("clr2 done stall", {31'd0, mem_stall}, 32'd0);
        chk("clr2 data", mem_read_val, 32'd0);
        tick();
        mem_read_en = 1'b0;

        // Reset while in READ_WAIT.
        do_write(8'h30, 32'hA5A5_A5A5, "rw30");
        mem_addr = 8'h30; mem_read_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rwait data", mem_read_val, 32'hA5A5_A5A5);
        reset = 1'b1; mem_read_en = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rwait rst read_val", mem_read_val, 32'd0);
        chk("rwait rst ready", {31'd0, mem_ready}, 32'd0);
        tick();
        count_clear(n);
        chk("rwait clear len", n, 32'd255);
        do_read(8'h30, 32'd0, "rwait cleared");

        // Reset at clear cycle 200 restarts the full clear.
        apply_reset(1);
        repeat (200) tick();
        apply_reset(1);
        @(negedge clk);
        chk("mid rst ready", {31'd0, mem_ready}, 32'd0);
        tick();
        count_clear(n);
        chk("mid clear len", n, 32'd255);
        do_read(8'hFF, 32'd0, "mid cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
